// File: rtl/bpm_threshold_pipe.sv
// BPM-driven per-channel pixel thresholding with a single output register.
// Threshold slews toward a BPM-derived target once per frame, at sop.
module bpm_threshold_pipe #(
  parameter int BITS      = 8,
  parameter int CHANNELS  = 3,
  parameter int MAX_BPM   = 200,
  parameter int STEP_SIZE = (256*256)/MAX_BPM,
  parameter int SLEW      = 16,
  parameter int CNT_W     = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BITS*CHANNELS-1:0]      pix_in,
  input  logic                          sop_in,
  input  logic                          eop_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  input  logic [$clog2(MAX_BPM+1)-1:0]  bpm_in,
  input  logic [1:0]                    mode,
  output logic [BITS*CHANNELS-1:0]      pix_out,
  output logic                          sop_out,
  output logic                          eop_out,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic [BITS-1:0]               threshold,
  output logic [CNT_W-1:0]              zeroed_count
);

  localparam int PW = BITS*CHANNELS;
  localparam logic [BITS-1:0]  PIX_MAX = '1;
  localparam logic [BITS-1:0]  SLEW_V  = BITS'(SLEW);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [63:0]      prod;
  logic [63:0]      scaled;
  logic [BITS-1:0]  target;
  logic [BITS-1:0]  gap;
  logic [BITS-1:0]  thr_q;
  logic [BITS-1:0]  thr_nx;
  logic [BITS-1:0]  thr_eff;
  logic [1:0]       mode_q;
  logic [1:0]       mode_eff;
  logic [PW-1:0]    pix_proc;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_nx;
  logic             accept;
  logic             hit_zero;

  assign ready_out = !valid_out || ready_in;
  assign accept    = valid_in && ready_out;
  assign threshold = thr_q;

  // Full-width product so large BPM values saturate instead of wrapping.
  assign prod   = 64'(STEP_SIZE) * 64'(bpm_in);
  assign scaled = prod >> 8;
  assign target = (scaled > 64'(PIX_MAX)) ? PIX_MAX : scaled[BITS-1:0];

  // Slew-limited step of the threshold toward the target.
  always_comb begin
    thr_nx = thr_q;
    gap    = '0;
    if (target > thr_q) begin
      gap    = target - thr_q;
      thr_nx = thr_q + ((gap > SLEW_V) ? SLEW_V : gap);
    end else begin
      gap    = thr_q - target;
      thr_nx = thr_q - ((gap > SLEW_V) ? SLEW_V : gap);
    end
  end

  // The sop beat already sees the freshly updated threshold and mode.
  assign thr_eff  = sop_in ? thr_nx : thr_q;
  assign mode_eff = sop_in ? mode : mode_q;

  function automatic logic [BITS-1:0] apply_mode(
    input logic [BITS-1:0] c,
    input logic [1:0]      m,
    input logic [BITS-1:0] t
  );
    logic [BITS-1:0] r;
    r = c;
    unique case (1'b1)
      (m == 2'd1): r = (c <= t) ? '0 : c;
      (m == 2'd2): r = (c > t) ? PIX_MAX : '0;
      default:     r = c;
    endcase
    return r;
  endfunction

  // Per-channel thresholding of the incoming pixel.
  always_comb begin
    pix_proc = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pix_proc[i*BITS +: BITS] =
        apply_mode(pix_in[i*BITS +: BITS], mode_eff, thr_eff);
    end
  end

  // Zeroed-pixel count: restart at sop, saturate at the top.
  always_comb begin
    hit_zero = (mode_eff != 2'd0) && (pix_proc == '0);
    cnt_base = sop_in ? '0 : cnt_q;
    cnt_nx   = cnt_base;
    if (hit_zero && (cnt_base != CNT_MAX)) cnt_nx = cnt_base + 1'b1;
  end

  // Output register: the only pipeline stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
      pix_out   <= '0;
    end else if (ready_out) begin
      valid_out <= valid_in;
      if (valid_in) begin
        pix_out <= pix_proc;
        sop_out <= sop_in;
        eop_out <= eop_in;
      end
    end
  end

  // Frame state: threshold, latched mode, running and reported counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      thr_q        <= '0;
      mode_q       <= 2'd0;
      cnt_q        <= '0;
      zeroed_count <= '0;
    end else if (accept) begin
      if (sop_in) begin
        thr_q  <= thr_nx;
        mode_q <= mode;
      end
      cnt_q <= cnt_nx;
      if (eop_in) zeroed_count <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_bpm_threshold_pipe.sv
// Self-checking bench for bpm_threshold_pipe.
// Directed scenarios plus randomized traffic against a frame-level model.
module tb_bpm_threshold_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] pix_in;
  logic        sop_in, eop_in, valid_in, ready_in;
  logic        ready_out;
  logic [7:0]  bpm_in;
  logic [1:0]  mode;
  logic [23:0] pix_out;
  logic        sop_out, eop_out, valid_out;
  logic [7:0]  threshold;
  logic [19:0] zeroed_count;

  bpm_threshold_pipe dut (
    .clk(clk), .reset(reset), .pix_in(pix_in),
    .sop_in(sop_in), .eop_in(eop_in), .valid_in(valid_in),
    .ready_out(ready_out), .bpm_in(bpm_in), .mode(mode),
    .pix_out(pix_out), .sop_out(sop_out), .eop_out(eop_out),
    .valid_out(valid_out), .ready_in(ready_in),
    .threshold(threshold), .zeroed_count(zeroed_count)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  int m_thr, m_mode, m_cnt, m_zc;
  logic [25:0] q[$];
  bit          emi, acc, exp_ok;
  logic [25:0] got, expv;

  function automatic int ch_out(int c, int md, int t);
    if (md == 1) return (c <= t) ? 0 : c;
    if (md == 2) return (c > t) ? 255 : 0;
    return c;
  endfunction

  task automatic model_reset();
    m_thr = 0; m_mode = 0; m_cnt = 0; m_zc = 0;
    q.delete();
  endtask

  task automatic model_accept();
    int tgt, o, all0;
    logic [23:0] op;
    if (sop_in) begin
      tgt = (327 * int'(bpm_in)) / 256;
      if (tgt > 255) tgt = 255;
      if (tgt > m_thr) m_thr += (tgt - m_thr > 16) ? 16 : tgt - m_thr;
      else m_thr -= (m_thr - tgt > 16) ? 16 : m_thr - tgt;
      m_mode = int'(mode);
      m_cnt = 0;
    end
    all0 = 1;
    for (int i = 0; i < 3; i++) begin
      o = ch_out(int'(pix_in[i*8 +: 8]), m_mode, m_thr);
      op[i*8 +: 8] = 8'(o);
      if (o != 0) all0 = 0;
    end
    if (m_mode != 0 && all0 == 1 && m_cnt < 20'hFFFFF) m_cnt++;
    if (eop_in) m_zc = m_cnt;
    q.push_back({op, sop_in, eop_in});
  endtask

  task automatic tick();
    @(negedge clk);
    emi = valid_out && ready_in;
    acc = valid_in && ready_out && !reset;
    if (emi) begin
      got = {pix_out, sop_out, eop_out};
      exp_ok = q.size() > 0;
      expv = exp_ok ? q.pop_front() : '0;
    end
    if (reset) model_reset();
    else if (acc) model_accept();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b1; sop_in = 1'b1; eop_in = 1'b0;
    ready_in = 1'b1; pix_in = 24'hABCDEF; bpm_in = 8'd100; mode = 2'd1;
    tick(); tick();
    total++; if (valid_out !== 1'b0) $display("FAIL rst_valid got=%b exp=0", valid_out); else passes++;
    total++; if (sop_out !== 1'b0 || eop_out !== 1'b0) $display("FAIL rst_sop_eop got=%b%b exp=00", sop_out, eop_out); else passes++;
    total++; if (pix_out !== 24'd0) $display("FAIL rst_pix got=%h exp=0", pix_out); else passes++;
    total++; if (threshold !== 8'd0) $display("FAIL rst_thr got=%0d exp=0", threshold); else passes++;
    total++; if (zeroed_count !== 20'd0) $display("FAIL rst_zc got=%0d exp=0", zeroed_count); else passes++;
    reset = 1'b0; valid_in = 1'b0; sop_in = 1'b0; ready_in = 1'b0;
    tick();
    total++; if (ready_out !== 1'b1) $display("FAIL rst_ready got=%b exp=1", ready_out); else passes++;
    ready_in = 1'b1;
  endtask

  task automatic test_ramp();
    int exp_thr[8] = '{16, 32, 48, 64, 80, 96, 112, 127};
    bpm_in = 8'd100; mode = 2'd1; ready_in = 1'b1; valid_in = 1'b1;
    for (int f = 0; f < 8; f++) begin
      for (int p = 0; p < 4; p++) begin
        sop_in = (p == 0); eop_in = (p == 3); pix_in = 24'($urandom);
        tick();
        if (p == 0) begin
          total++;
          if (threshold !== 8'(exp_thr[f])) $display("FAIL ramp_thr f=%0d got=%0d exp=%0d", f, threshold, exp_thr[f]);
          else passes++;
        end
        if (emi) begin
          total++;
          if (!exp_ok || got !== expv) $display("FAIL ramp_beat got=%h exp=%h", got, expv); else passes++;
        end
      end
    end
    valid_in = 1'b0; tick();
    total++; if (!emi || got !== expv) $display("FAIL ramp_last got=%h exp=%h", got, expv); else passes++;
  endtask

  task automatic test_compare();
    bpm_in = 8'd100; mode = 2'd1; valid_in = 1'b1; sop_in = 1'b1; eop_in = 1'b1;
    pix_in = {8'd127, 8'd128, 8'd127};
    tick();
    total++; if (threshold !== 8'd127) $display("FAIL cmp_thr got=%0d exp=127", threshold); else passes++;
    valid_in = 1'b0; mode = 2'd2; tick();
    total++; if (!emi || got[25:2] !== {8'd0, 8'd128, 8'd0}) $display("FAIL cmp_zero got=%h exp=008000", got[25:2]); else passes++;
    valid_in = 1'b1; tick();
    valid_in = 1'b0; mode = 2'd1; tick();
    total++; if (!emi || got[25:2] !== {8'd0, 8'd255, 8'd0}) $display("FAIL cmp_bin got=%h exp=00ff00", got[25:2]); else passes++;
  endtask

  task automatic test_zero_count();
    logic [9:0] mask = 10'b0110101101;
    logic [23:0] px;
    bpm_in = 8'd100; mode = 2'd1; valid_in = 1'b1;
    for (int p = 0; p < 10; p++) begin
      px = {8'($urandom_range(0, 127)), 8'($urandom_range(0, 127)), 8'($urandom_range(0, 127))};
      if (!mask[p]) px[8*($urandom % 3) +: 8] = 8'($urandom_range(128, 255));
      sop_in = (p == 0); eop_in = (p == 9); pix_in = px;
      tick();
      if (emi) begin
        total++;
        if (!exp_ok || got !== expv) $display("FAIL zc_beat got=%h exp=%h", got, expv); else passes++;
      end
    end
    total++; if (zeroed_count !== 20'd6) $display("FAIL zc_frame10 got=%0d exp=6", zeroed_count); else passes++;
    sop_in = 1'b1; eop_in = 1'b1; pix_in = {8'd5, 8'd127, 8'd0};
    tick();
    total++; if (zeroed_count !== 20'd1) $display("FAIL zc_single_below got=%0d exp=1", zeroed_count); else passes++;
    pix_in = {8'd5, 8'd200, 8'd0};
    tick();
    total++; if (zeroed_count !== 20'd0) $display("FAIL zc_single_above got=%0d exp=0", zeroed_count); else passes++;
    valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0; tick(); tick();
  endtask

  task automatic test_saturation();
    int e;
    bpm_in = 8'd200; mode = 2'd0; valid_in = 1'b1; sop_in = 1'b1; eop_in = 1'b1;
    for (int f = 0; f < 9; f++) begin
      pix_in = 24'($urandom);
      tick();
      e = 127 + 16 * (f + 1); if (e > 255) e = 255;
      total++;
      if (threshold !== 8'(e)) $display("FAIL sat200 f=%0d got=%0d exp=%0d", f, threshold, e); else passes++;
    end
    bpm_in = 8'd255; tick();
    total++; if (threshold !== 8'd255) $display("FAIL sat255 got=%0d exp=255", threshold); else passes++;
    valid_in = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int n_emit = 0;
    int cyc = 0;
    logic [23:0] held;
    mode = 2'd0; valid_in = 1'b1;
    while (idx < 12 && cyc < 40) begin
      sop_in = (idx == 0); eop_in = (idx == 11); pix_in = 24'h100000 + 24'(idx);
      ready_in = !(cyc >= 3 && cyc < 8);
      held = pix_out;
      tick();
      if (emi) begin
        n_emit++; total++;
        if (!exp_ok || got !== expv) $display("FAIL bp_beat got=%h exp=%h", got, expv); else passes++;
      end
      if (!ready_in) begin
        total++;
        if (ready_out !== 1'b0 || (cyc > 3 && pix_out !== held))
          $display("FAIL bp_stall cyc=%0d ready=%b pix=%h exp_ready=0 exp_pix=%h", cyc, ready_out, pix_out, held);
        else passes++;
      end
      if (cyc == 8) begin
        total++; if (!emi) $display("FAIL bp_resume got=0 exp=1"); else passes++;
      end
      if (acc) idx++;
      cyc++;
    end
    total++; if (idx != 12) $display("FAIL bp_budget got=%0d exp=12", idx); else passes++;
    valid_in = 1'b0; ready_in = 1'b1;
    tick();
    if (emi) begin
      n_emit++; total++;
      if (!exp_ok || got !== expv) $display("FAIL bp_beat got=%h exp=%h", got, expv); else passes++;
    end
    total++; if (n_emit != 12) $display("FAIL bp_count got=%0d exp=12", n_emit); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [23:0] psent;
    reset = 1'b1; tick(); reset = 1'b0;
    bpm_in = 8'd100; mode = 2'd1; valid_in = 1'b1; ready_in = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 2; p++) begin
        sop_in = (p == 0); eop_in = (p == 1); pix_in = 24'($urandom); tick();
      end
    end
    sop_in = 1'b1; eop_in = 1'b0; pix_in = 24'($urandom); tick();
    total++; if (threshold !== 8'd64) $display("FAIL rm_thr64 got=%0d exp=64", threshold); else passes++;
    sop_in = 1'b0; pix_in = 24'h000001; tick();
    reset = 1'b1; pix_in = 24'($urandom); tick();
    total++;
    if (valid_out !== 1'b0 || sop_out !== 1'b0 || eop_out !== 1'b0 || pix_out !== 24'd0 || threshold !== 8'd0 || zeroed_count !== 20'd0)
      $display("FAIL rm_clear got=%b%b%b %h %0d %0d exp=000 0 0 0", valid_out, sop_out, eop_out, pix_out, threshold, zeroed_count);
    else passes++;
    reset = 1'b0; psent = 24'h3A1F07; pix_in = psent; tick();
    valid_in = 1'b0; tick();
    total++; if (!emi || got[25:2] !== psent) $display("FAIL rm_bypass got=%h exp=%h", got[25:2], psent); else passes++;
    valid_in = 1'b1; sop_in = 1'b1; eop_in = 1'b1; tick();
    total++; if (threshold !== 8'd16) $display("FAIL rm_ramp got=%0d exp=16", threshold); else passes++;
    valid_in = 1'b0; tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      valid_in = ($urandom % 4) != 0; ready_in = ($urandom % 4) != 0;
      sop_in = ($urandom % 6) == 0; eop_in = ($urandom % 6) == 0;
      bpm_in = 8'($urandom); mode = 2'($urandom % 3); pix_in = 24'($urandom);
      if ($urandom % 2 == 0) pix_in[7:0] = 8'($urandom % 64);
      tick();
      if (emi) begin
        total++;
        if (!exp_ok || got !== expv) $display("FAIL rnd_beat k=%0d got=%h exp=%h", k, got, expv); else passes++;
      end
      total++; if (threshold !== 8'(m_thr)) $display("FAIL rnd_thr k=%0d got=%0d exp=%0d", k, threshold, m_thr); else passes++;
      total++; if (zeroed_count !== 20'(m_zc)) $display("FAIL rnd_zc k=%0d got=%0d exp=%0d", k, zeroed_count, m_zc); else passes++;
    end
    valid_in = 1'b0; ready_in = 1'b1; tick();
    if (emi) begin
      total++;
      if (!exp_ok || got !== expv) $display("FAIL rnd_drain got=%h exp=%h", got, expv); else passes++;
    end
    total++; if (q.size() != 0) $display("FAIL rnd_leftover got=%0d exp=0", q.size()); else passes++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ramp();
    test_compare();
    test_zero_count();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
